// File: rtl/prog_loader_pkg.sv
// rtl/prog_loader_pkg.sv - shared FSM encoding and shift-width helper for the serial program loader
package prog_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  // Number of serial bits that make up one complete word in the given mode.
  function automatic int shift_width(input logic auto_mode, input int addr_w, input int data_w);
    return auto_mode ? data_w : addr_w + data_w;
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// rtl/prog_loader_if.sv - program RAM write bus driven by the loader
interface prog_loader_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  modport master (output mem_write, output mem_addr, output mem_wdata);
  modport slave  (input  mem_write, input  mem_addr, input  mem_wdata);
endinterface

// File: rtl/prog_loader_pin_sync.sv
// rtl/prog_loader_pin_sync.sv - multi-flop synchroniser with rising-edge detect for one async pin
module pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic nreset,
  input  logic pin,
  output logic sync,
  output logic rise
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   hist;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      chain <= '0;
      hist  <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], pin};
      hist  <= chain[SYNC_STAGES-1];
    end
  end

  assign sync = chain[SYNC_STAGES-1];
  assign rise = sync & ~hist;

endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - serial programming loader: shifts words in from pins and writes program RAM
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              prg,
  input  logic              ser_din,
  input  logic              ser_clk,
  input  logic              ser_latch,
  input  logic              auto_inc,
  output logic              core_halt,
  prog_loader_if.master     mem,
  output logic [DATA_W-1:0] checksum,
  output logic [ADDR_W:0]   word_count,
  output logic              bit_count_err
);

  localparam int SR_W  = ADDR_W + DATA_W;
  localparam int CNT_W = $clog2(SR_W + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [ADDR_W:0]  WC_MAX  = {1'b1, {ADDR_W{1'b0}}};

  logic prg_s, prg_rise, din_s, din_rise, sclk_s, sclk_rise, latch_s, latch_rise;
  logic unused_sync;

  pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_prg   (.clk(clk), .nreset(nreset), .pin(prg),       .sync(prg_s),   .rise(prg_rise));
  pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_din   (.clk(clk), .nreset(nreset), .pin(ser_din),   .sync(din_s),   .rise(din_rise));
  pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk  (.clk(clk), .nreset(nreset), .pin(ser_clk),   .sync(sclk_s),  .rise(sclk_rise));
  pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_latch (.clk(clk), .nreset(nreset), .pin(ser_latch), .sync(latch_s), .rise(latch_rise));

  assign unused_sync = prg_rise | din_rise | sclk_s | latch_s;

  state_t            state_q, state_d;
  logic [SR_W-1:0]   sr;
  logic [CNT_W-1:0]  bit_cnt;
  logic [CNT_W-1:0]  exp_cnt;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              auto_q;
  logic              write_q;
  logic              halt_q;
  logic              enter_armed, shift_en, commit, latch_bad;

  assign exp_cnt = CNT_W'(shift_width(auto_q, ADDR_W, DATA_W));

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= ST_IDLE;
      write_q <= 1'b0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      write_q <= (state_d == ST_WRITE);
      halt_q  <= (state_d != ST_IDLE);
    end
  end

  // A latch rise takes priority over a coincident shift rise; dropping prg wins over both.
  always_comb begin
    state_d     = state_q;
    enter_armed = 1'b0;
    shift_en    = 1'b0;
    commit      = 1'b0;
    latch_bad   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (prg_s) begin
          state_d     = ST_ARMED;
          enter_armed = 1'b1;
        end
      end
      ST_ARMED: begin
        if (!prg_s) begin
          state_d = ST_IDLE;
        end else if (latch_rise) begin
          if (bit_cnt == exp_cnt) begin
            state_d = ST_WRITE;
            commit  = 1'b1;
          end else begin
            latch_bad = 1'b1;
          end
        end else if (sclk_rise) begin
          shift_en = 1'b1;
        end
      end
      ST_WRITE: state_d = prg_s ? ST_ARMED : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      sr            <= '0;
      bit_cnt       <= '0;
      ptr           <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      auto_q        <= 1'b0;
      checksum      <= '0;
      word_count    <= '0;
      bit_count_err <= 1'b0;
    end else if (enter_armed) begin
      sr            <= '0;
      bit_cnt       <= '0;
      ptr           <= '0;
      auto_q        <= auto_inc;
      checksum      <= '0;
      word_count    <= '0;
      bit_count_err <= 1'b0;
    end else if (shift_en) begin
      sr <= {sr[SR_W-2:0], din_s};
      if (bit_cnt != CNT_MAX) bit_cnt <= bit_cnt + 1'b1;
    end else if (latch_bad) begin
      bit_count_err <= 1'b1;
      bit_cnt       <= '0;
    end else if (commit) begin
      addr_q  <= auto_q ? ptr : sr[SR_W-1:DATA_W];
      wdata_q <= sr[DATA_W-1:0];
    end else if (state_q == ST_WRITE) begin
      checksum <= checksum + wdata_q;
      if (word_count != WC_MAX) word_count <= word_count + 1'b1;
      ptr     <= addr_q + 1'b1;
      bit_cnt <= '0;
    end
  end

  assign core_halt     = halt_q;
  assign mem.mem_write = write_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - directed self-checking bench for prog_loader (8-bit and 4-bit address instances)
module tb_prog_loader;

  logic clk = 1'b0;
  logic nreset, prg, prg4, ser_din, ser_clk, ser_latch, auto_inc;
  logic       halt8, err8, halt4, err4;
  logic [7:0] csum8, csum4;
  logic [8:0] wc8;
  logic [4:0] wc4;

  int pass_cnt = 0;
  int tot_cnt  = 0;
  int cyc      = 0;

  prog_loader_if #(.ADDR_W(8), .DATA_W(8)) mem8 ();
  prog_loader_if #(.ADDR_W(4), .DATA_W(8)) mem4 ();

  prog_loader #(.ADDR_W(8), .DATA_W(8), .SYNC_STAGES(2)) dut8 (
    .clk(clk), .nreset(nreset), .prg(prg), .ser_din(ser_din), .ser_clk(ser_clk),
    .ser_latch(ser_latch), .auto_inc(auto_inc), .core_halt(halt8), .mem(mem8),
    .checksum(csum8), .word_count(wc8), .bit_count_err(err8));

  prog_loader #(.ADDR_W(4), .DATA_W(8), .SYNC_STAGES(2)) dut4 (
    .clk(clk), .nreset(nreset), .prg(prg4), .ser_din(ser_din), .ser_clk(ser_clk),
    .ser_latch(ser_latch), .auto_inc(auto_inc), .core_halt(halt4), .mem(mem4),
    .checksum(csum4), .word_count(wc4), .bit_count_err(err4));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] wr8_addr [32];
  logic [7:0] wr8_data [32];
  int         wr8_cyc  [32];
  int         wr8_n = 0;
  logic [3:0] wr4_addr [32];
  logic [7:0] wr4_data [32];
  int         wr4_n = 0;

  always @(negedge clk) begin
    if (mem8.mem_write === 1'b1) begin
      if (wr8_n < 32) begin
        wr8_addr[wr8_n] = mem8.mem_addr;
        wr8_data[wr8_n] = mem8.mem_wdata;
        wr8_cyc[wr8_n]  = cyc;
      end
      wr8_n++;
    end
    if (mem4.mem_write === 1'b1) begin
      if (wr4_n < 32) begin
        wr4_addr[wr4_n] = mem4.mem_addr;
        wr4_data[wr4_n] = mem4.mem_wdata;
      end
      wr4_n++;
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic shift_bit(input logic b);
    ser_din = b;
    wait_cyc(4);
    ser_clk = 1'b1;
    wait_cyc(4);
    ser_clk = 1'b0;
    wait_cyc(4);
  endtask

  task automatic shift_word(input logic [15:0] w, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) shift_bit(w[i]);
  endtask

  task automatic latch_pulse(output int t0);
    t0 = cyc;
    ser_latch = 1'b1;
    wait_cyc(4);
    ser_latch = 1'b0;
    wait_cyc(4);
  endtask

  task automatic test_reset;
    int bad = 0;
    nreset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      prg = i[0]; ser_clk = i[1]; ser_latch = i[2]; ser_din = i[3]; prg4 = i[1];
      @(negedge clk);
      if (halt8 !== 1'b0 || mem8.mem_write !== 1'b0 || mem8.mem_addr !== 8'h0 || mem8.mem_wdata !== 8'h0 ||
          csum8 !== 8'h0 || wc8 !== 9'h0 || err8 !== 1'b0 || halt4 !== 1'b0 || mem4.mem_write !== 1'b0)
        bad++;
    end
    tot_cnt++;
    if (bad !== 0) $display("FAIL reset_outputs: %0d cycles with nonzero outputs, required 0", bad);
    else pass_cnt++;
    prg = 0; prg4 = 0; ser_clk = 0; ser_latch = 0; ser_din = 0;
    wait_cyc(2);
    nreset = 1'b1;
    wait_cyc(8);
    tot_cnt++;
    if (halt8 !== 1'b0) $display("FAIL reset_release_halt: core_halt=%b required 0", halt8);
    else pass_cnt++;
    tot_cnt++;
    if (wr8_n !== 0 || wr4_n !== 0) $display("FAIL reset_no_write: writes=%0d/%0d required 0/0", wr8_n, wr4_n);
    else pass_cnt++;
  endtask

  task automatic test_explicit;
    int t0;
    auto_inc = 1'b0;
    prg = 1'b1;
    wait_cyc(6);
    tot_cnt++;
    if (halt8 !== 1'b1) $display("FAIL explicit_halt: core_halt=%b required 1", halt8);
    else pass_cnt++;
    wr8_n = 0;
    shift_word(16'h12A5, 16);
    latch_pulse(t0);
    wait_cyc(2);
    tot_cnt++;
    if (wr8_n !== 1) $display("FAIL explicit_count: writes=%0d required 1", wr8_n);
    else pass_cnt++;
    tot_cnt++;
    if (wr8_addr[0] !== 8'h12 || wr8_data[0] !== 8'hA5)
      $display("FAIL explicit_word: addr=%h data=%h required 12/a5", wr8_addr[0], wr8_data[0]);
    else pass_cnt++;
    tot_cnt++;
    if (wr8_cyc[0] - t0 !== 3) $display("FAIL explicit_latency: %0d edges required 3", wr8_cyc[0] - t0);
    else pass_cnt++;
    tot_cnt++;
    if (csum8 !== 8'hA5 || wc8 !== 9'd1 || err8 !== 1'b0)
      $display("FAIL explicit_accum: checksum=%h count=%0d err=%b required a5/1/0", csum8, wc8, err8);
    else pass_cnt++;
    prg = 1'b0;
    wait_cyc(6);
  endtask

  task automatic test_auto;
    int t0;
    logic [7:0] words [3];
    words[0] = 8'h01; words[1] = 8'h02; words[2] = 8'hFF;
    auto_inc = 1'b1;
    prg = 1'b1;
    wait_cyc(6);
    wr8_n = 0;
    for (int i = 0; i < 3; i++) begin
      shift_word({8'h00, words[i]}, 8);
      latch_pulse(t0);
    end
    wait_cyc(2);
    tot_cnt++;
    if (wr8_n !== 3) $display("FAIL auto_count: writes=%0d required 3", wr8_n);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      tot_cnt++;
      if (wr8_addr[i] !== 8'(i) || wr8_data[i] !== words[i])
        $display("FAIL auto_word%0d: addr=%h data=%h required %h/%h", i, wr8_addr[i], wr8_data[i], 8'(i), words[i]);
      else pass_cnt++;
    end
    tot_cnt++;
    if (csum8 !== 8'h02 || wc8 !== 9'd3)
      $display("FAIL auto_accum: checksum=%h count=%0d required 02/3", csum8, wc8);
    else pass_cnt++;
    prg = 1'b0;
    auto_inc = 1'b0;
    wait_cyc(6);
  endtask

  task automatic test_bit_error;
    int t0;
    prg = 1'b1;
    wait_cyc(6);
    wr8_n = 0;
    shift_word(16'h7FFF, 15);
    latch_pulse(t0);
    wait_cyc(2);
    tot_cnt++;
    if (wr8_n !== 0 || err8 !== 1'b1)
      $display("FAIL biterr_flag: writes=%0d err=%b required 0/1", wr8_n, err8);
    else pass_cnt++;
    shift_word(16'h3C5A, 16);
    latch_pulse(t0);
    wait_cyc(2);
    tot_cnt++;
    if (wr8_n !== 1 || wr8_addr[0] !== 8'h3C || wr8_data[0] !== 8'h5A)
      $display("FAIL biterr_recover: writes=%0d addr=%h data=%h required 1/3c/5a", wr8_n, wr8_addr[0], wr8_data[0]);
    else pass_cnt++;
    tot_cnt++;
    if (err8 !== 1'b1 || csum8 !== 8'h5A || wc8 !== 9'd1)
      $display("FAIL biterr_sticky: err=%b checksum=%h count=%0d required 1/5a/1", err8, csum8, wc8);
    else pass_cnt++;
    prg = 1'b0;
    wait_cyc(6);
    tot_cnt++;
    if (err8 !== 1'b1) $display("FAIL biterr_idle_persist: err=%b required 1", err8);
    else pass_cnt++;
  endtask

  task automatic test_prg_drop;
    int t0;
    prg = 1'b1;
    wait_cyc(6);
    tot_cnt++;
    if (err8 !== 1'b0 || csum8 !== 8'h00 || wc8 !== 9'd0)
      $display("FAIL drop_entry_clear: err=%b checksum=%h count=%0d required 0/00/0", err8, csum8, wc8);
    else pass_cnt++;
    shift_word(16'h0005, 3);
    latch_pulse(t0);
    wr8_n = 0;
    shift_word(16'h4477, 16);
    ser_latch = 1'b1;
    @(negedge clk);
    prg = 1'b0;
    wait_cyc(3);
    ser_latch = 1'b0;
    wait_cyc(8);
    tot_cnt++;
    if (wr8_n !== 1 || wr8_addr[0] !== 8'h44 || wr8_data[0] !== 8'h77)
      $display("FAIL drop_write: writes=%0d addr=%h data=%h required 1/44/77", wr8_n, wr8_addr[0], wr8_data[0]);
    else pass_cnt++;
    tot_cnt++;
    if (halt8 !== 1'b0) $display("FAIL drop_halt: core_halt=%b required 0", halt8);
    else pass_cnt++;
    tot_cnt++;
    if (csum8 !== 8'h77 || wc8 !== 9'd1 || err8 !== 1'b1)
      $display("FAIL drop_persist: checksum=%h count=%0d err=%b required 77/1/1", csum8, wc8, err8);
    else pass_cnt++;
    prg = 1'b1;
    wait_cyc(6);
    tot_cnt++;
    if (csum8 !== 8'h00 || wc8 !== 9'd0 || err8 !== 1'b0 || halt8 !== 1'b1)
      $display("FAIL drop_reentry: checksum=%h count=%0d err=%b halt=%b required 00/0/0/1", csum8, wc8, err8, halt8);
    else pass_cnt++;
    prg = 1'b0;
    wait_cyc(6);
  endtask

  task automatic test_wrap_and_coincident;
    int t0;
    auto_inc = 1'b1;
    prg4 = 1'b1;
    wait_cyc(6);
    wr4_n = 0;
    for (int i = 1; i <= 17; i++) begin
      shift_word(16'(i), 8);
      latch_pulse(t0);
      if (i == 16) begin
        tot_cnt++;
        if (wc4 !== 5'd16) $display("FAIL wrap_count16: count=%0d required 16", wc4);
        else pass_cnt++;
      end
    end
    wait_cyc(2);
    tot_cnt++;
    if (wr4_n !== 17 || wr4_addr[15] !== 4'hF || wr4_addr[16] !== 4'h0 || wr4_data[16] !== 8'h11)
      $display("FAIL wrap_addr: writes=%0d a15=%h a16=%h d16=%h required 17/f/0/11",
               wr4_n, wr4_addr[15], wr4_addr[16], wr4_data[16]);
    else pass_cnt++;
    tot_cnt++;
    if (wc4 !== 5'd16 || csum4 !== 8'h99)
      $display("FAIL wrap_saturate: count=%0d checksum=%h required 16/99", wc4, csum4);
    else pass_cnt++;
    shift_word(16'h00AB, 8);
    ser_din = 1'b1;
    ser_clk = 1'b1;
    ser_latch = 1'b1;
    wait_cyc(4);
    ser_clk = 1'b0;
    ser_latch = 1'b0;
    wait_cyc(6);
    tot_cnt++;
    if (wr4_n !== 18 || wr4_addr[17] !== 4'h1 || wr4_data[17] !== 8'hAB || err4 !== 1'b0)
      $display("FAIL coincident: writes=%0d addr=%h data=%h err=%b required 18/1/ab/0",
               wr4_n, wr4_addr[17], wr4_data[17], err4);
    else pass_cnt++;
    tot_cnt++;
    if (wc4 !== 5'd16 || csum4 !== 8'h44 || wr8_n !== 0)
      $display("FAIL coincident_accum: count=%0d checksum=%h dut8_writes=%0d required 16/44/0", wc4, csum4, wr8_n);
    else pass_cnt++;
    prg4 = 1'b0;
    wait_cyc(6);
  endtask

  initial begin
    nreset = 1'b0; prg = 0; prg4 = 0; ser_din = 0; ser_clk = 0; ser_latch = 0; auto_inc = 0;
    test_reset();
    test_explicit();
    test_auto();
    test_bit_error();
    test_prg_drop();
    wr8_n = 0;
    test_wrap_and_coincident();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
